// File: rtl/rf_bank.sv
// Multi-port register file with write-through bypass, a pending-write scoreboard
// and a one-register-per-cycle clear sweep. Register 0 always reads as zero.
module rf_bank #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_RD  = 2,
    parameter int SP_ADDR = 14,
    parameter int SP_RST  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        hazard,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     iss_vld,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     clr_done
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] SP_IDX   = ADDR_W'(SP_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] SP_VAL   = DATA_W'(SP_RST);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   sp_reg;
    logic [DEPTH-1:0]    pending;
    logic [DEPTH-1:0]    pending_next;
    logic                wr_ok;

    assign wr_ok = we && (w_addr != '0) && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clr_req) next_state = CLEAR;
            CLEAR:   if (cnt == LAST_IDX) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CLEAR);
    end

    // The sweep counter idles at 1 so the first CLEAR cycle already targets register 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= ADDR_W'(1);
            clr_done <= 1'b0;
        end else begin
            cnt      <= (state == CLEAR) ? cnt + 1'b1 : ADDR_W'(1);
            clr_done <= (state == CLEAR) && (cnt == LAST_IDX);
        end
    end

    // The stack pointer lives outside the RAM so the rest of the file needs no reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_reg <= SP_VAL;
        end else if ((state == CLEAR) && (cnt == SP_IDX)) begin
            sp_reg <= SP_VAL;
        end else if (wr_ok && (w_addr == SP_IDX)) begin
            sp_reg <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[w_addr] <= wdata;
        end
    end

    // A same-cycle issue wins over the write that retires the same register.
    always_comb begin
        pending_next = pending;
        if ((state == CLEAR) || clr_req) begin
            pending_next = '0;
        end else begin
            if (wr_ok) pending_next[w_addr] = 1'b0;
            if (iss_vld && (iss_addr != '0)) pending_next[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_port
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;
        logic [DATA_W-1:0] q;
        logic              wr_hit;

        assign ra     = rd_addr[g*ADDR_W +: ADDR_W];
        assign wr_hit = wr_ok && (w_addr == ra);

        always_comb begin
            if (ra == '0) begin
                rv = '0;
            end else if (wr_hit) begin
                rv = wdata;
            end else if (ra == SP_IDX) begin
                rv = sp_reg;
            end else begin
                rv = mem[ra];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (state == CLEAR) begin
                q <= '0;
            end else begin
                q <= rv;
            end
        end

        assign rd_data[g*DATA_W +: DATA_W] = (state == CLEAR) ? '0 : q;
        assign hazard[g] = (state == IDLE) && (ra != '0) && pending[ra] && !wr_hit;
    end

endmodule

// File: doc/rf_bank.md
RF_BANK -- requirements
Module: rf_bank

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 4, register address width; DEPTH = 2**ADDR_W.
REQ-003 SHALL provide parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL provide parameter SP_ADDR, default 14, stack-pointer register index.
REQ-005 SHALL provide parameter SP_RST, default 0, stack-pointer reset/clear value.
REQ-006 SHALL provide clk  input  1  rising-edge clock.
REQ-007 SHALL provide rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL provide rd_addr  input  NUM_RD*ADDR_W  packed read addresses, port i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL provide rd_data  output  NUM_RD*DATA_W  packed registered read data.
REQ-010 SHALL provide hazard  output  NUM_RD  per-port pending-write flag, combinational.
REQ-011 SHALL provide we  input  1  write enable.
REQ-012 SHALL provide w_addr  input  ADDR_W  write address.
REQ-013 SHALL provide wdata  input  DATA_W  write data.
REQ-014 SHALL provide iss_vld  input  1  issue strobe marking iss_addr as pending.
REQ-015 SHALL provide iss_addr  input  ADDR_W  destination of issued instruction.
REQ-016 SHALL provide clr_req  input  1  request to clear the whole file.
REQ-017 SHALL provide busy  output  1  high while clear sweep runs.
REQ-018 SHALL provide clr_done  output  1  one-cycle pulse at sweep completion.

Function
REQ-019 SHALL hold register 0 as constant zero; writes and issues to address 0 ignored.
REQ-020 SHALL write mem[w_addr] <= wdata on posedge when we=1, w_addr!=0, state IDLE.
REQ-021 SHALL update each rd_data port on posedge, 1-cycle latency: 0 if rd_addr=0; wdata if we=1 and w_addr=rd_addr!=0 (write-through bypass); else mem[rd_addr].
REQ-022 SHALL keep a DEPTH-bit pending vector: set pending[iss_addr] on iss_vld (iss_addr!=0); clear pending[w_addr] on valid write.
REQ-023 SHALL give set priority when iss_vld and we target the same address in the same cycle (pending stays 1).
REQ-024 SHALL drive hazard[i] = pending[rd_addr_i] AND NOT (we AND w_addr=rd_addr_i AND w_addr!=0); hazard[i]=0 for rd_addr_i=0.
REQ-025 SHALL implement FSM states IDLE and CLEAR; IDLE->CLEAR on clr_req=1.
REQ-026 SHALL, on entering CLEAR, clear all pending bits and load sweep counter with 1.
REQ-027 SHALL, in CLEAR, write one register per cycle at counter index: SP_RST if index=SP_ADDR, else 0; counter increments.
REQ-028 SHALL, after writing index DEPTH-1, return to IDLE and pulse clr_done for exactly that same cycle's following clock (one cycle high).
REQ-029 SHALL hold busy=1 for exactly DEPTH-1 cycles per sweep.
REQ-030 SHALL ignore we, iss_vld and clr_req while busy=1; rd_data forced to 0 and hazard to 0 during CLEAR.
REQ-031 SHALL allow a new clr_req in the cycle clr_done is high, starting a new sweep next cycle.

Reset
REQ-032 SHALL on rst_n=0 set mem[SP_ADDR]=SP_RST, pending=0, state IDLE, counter 1, rd_data=0, busy=0, clr_done=0.
REQ-033 SHALL leave other memory entries unreset (RAM-inferable); contents undefined until written or cleared.
REQ-034 SHALL abort a sweep in progress on reset assertion; no clr_done pulse for the aborted sweep.

Verification
REQ-035 SHALL verify reset: rst_n low then high, read addr 14 -> rd_data=0x0000 next cycle, busy=0, hazard=0.
REQ-036 SHALL verify bypass: we=1, w_addr=3, wdata=0xBEEF with rd_addr0=3 -> rd_data0=0xBEEF after one clock; write to addr 0 with 0x1234 then read 0 -> 0x0000.
REQ-037 SHALL verify scoreboard: iss_vld addr 5 -> hazard=1 on port reading 5; same-cycle we to 5 -> hazard=0; next cycle pending cleared; simultaneous iss_vld+we to 5 -> pending stays 1.
REQ-038 SHALL verify clear: fill regs with 0xA5A5, clr_req one cycle -> busy high 15 cycles, clr_done one pulse, then reg 14 reads SP_RST, regs 1-13 and 15 read 0, we during sweep has no effect.
REQ-039 SHALL verify reset mid-sweep at cycle 7 -> busy=0, no clr_done, mem[14]=SP_RST.
REQ-040 SHALL verify NUM_RD=3, DATA_W=32 build: three ports read distinct addresses 1,2,3 concurrently -> correct 32-bit values.
